// File: rtl/ccir656_rx.sv
// BT.656 receiver: locks onto FF 00 00 XY timing codes, recovers F/V/H state and
// emits active-video bytes tagged with their Cb/Y0/Cr/Y1 position.
module ccir656_rx #(
  parameter int ACTIVE_BYTES = 1440,
  parameter int LINE_W       = 10
) (
  input  logic              clk27M,
  input  logic              rst_n,
  input  logic [7:0]        din,
  output logic [7:0]        pix_data,
  output logic              pix_valid,
  output logic [1:0]        pix_phase,
  output logic              sav_pulse,
  output logic              eav_pulse,
  output logic              field,
  output logic              vblank,
  output logic              hblank,
  output logic [LINE_W-1:0] line_cnt,
  output logic              code_err,
  output logic              len_err,
  output logic              sync_lock
);

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(ACTIVE_BYTES - 1);

  typedef enum logic [2:0] {
    SEARCH,
    PRE1,
    PRE2,
    PRE3,
    BLANK,
    ACTIVE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        pix_data_q, pix_data_d;
  logic              pix_valid_q, pix_valid_d;
  logic [1:0]        pix_phase_q, pix_phase_d;
  logic              sav_q, sav_d;
  logic              eav_q, eav_d;
  logic              field_q, field_d;
  logic              vblank_q, vblank_d;
  logic              hblank_q, hblank_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              code_err_q, code_err_d;
  logic              len_err_q, len_err_d;
  logic              lock_q, lock_d;
  logic [1:0]        vcnt_q, vcnt_d;

  logic xy_f, xy_v, xy_h, xy_ok;

  assign xy_f  = din[6];
  assign xy_v  = din[5];
  assign xy_h  = din[4];
  assign xy_ok = din[7] &&
                 (din[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    pix_phase_d = pix_phase_q;
    sav_d       = 1'b0;
    eav_d       = 1'b0;
    field_d     = field_q;
    vblank_d    = vblank_q;
    hblank_d    = hblank_q;
    line_d      = line_q;
    code_err_d  = 1'b0;
    len_err_d   = 1'b0;
    lock_d      = lock_q;
    vcnt_d      = vcnt_q;

    case (state_q)
      SEARCH, BLANK: begin
        if (din == 8'hFF) state_d = PRE1;
      end
      PRE1: begin
        if (din == 8'h00)      state_d = PRE2;
        else if (din == 8'hFF) state_d = PRE1;
        else                   state_d = SEARCH;
      end
      PRE2: begin
        if (din == 8'h00)      state_d = PRE3;
        else if (din == 8'hFF) state_d = PRE1;
        else                   state_d = SEARCH;
      end
      PRE3: begin
        if (xy_ok) begin
          field_d  = xy_f;
          vblank_d = xy_v;
          hblank_d = xy_h;
          // A field change restarts the line count even on an EAV.
          if (xy_f != field_q) line_d = '0;
          else if (xy_h)       line_d = line_q + LINE_W'(1);
          vcnt_d = (vcnt_q == 2'd2) ? 2'd2 : vcnt_q + 2'd1;
          if (vcnt_d == 2'd2) lock_d = 1'b1;
          if (xy_h) begin
            eav_d   = 1'b1;
            state_d = BLANK;
          end else begin
            sav_d       = 1'b1;
            cnt_d       = '0;
            pix_phase_d = 2'd0;
            state_d     = ACTIVE;
          end
        end else begin
          code_err_d = 1'b1;
          lock_d     = 1'b0;
          vcnt_d     = 2'd0;
          state_d    = SEARCH;
        end
      end
      ACTIVE: begin
        // FF never occurs in legal video, so it marks a truncated line.
        if (din == 8'hFF) begin
          len_err_d = 1'b1;
          lock_d    = 1'b0;
          vcnt_d    = 2'd0;
          state_d   = PRE1;
        end else begin
          pix_data_d  = din;
          pix_valid_d = ~vblank_q;
          pix_phase_d = cnt_q[1:0];
          cnt_d       = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BYTE) state_d = BLANK;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk27M or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      cnt_q       <= '0;
      pix_data_q  <= 8'h00;
      pix_valid_q <= 1'b0;
      pix_phase_q <= 2'd0;
      sav_q       <= 1'b0;
      eav_q       <= 1'b0;
      field_q     <= 1'b0;
      vblank_q    <= 1'b1;
      hblank_q    <= 1'b1;
      line_q      <= '0;
      code_err_q  <= 1'b0;
      len_err_q   <= 1'b0;
      lock_q      <= 1'b0;
      vcnt_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      pix_phase_q <= pix_phase_d;
      sav_q       <= sav_d;
      eav_q       <= eav_d;
      field_q     <= field_d;
      vblank_q    <= vblank_d;
      hblank_q    <= hblank_d;
      line_q      <= line_d;
      code_err_q  <= code_err_d;
      len_err_q   <= len_err_d;
      lock_q      <= lock_d;
      vcnt_q      <= vcnt_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign pix_phase = pix_phase_q;
  assign sav_pulse = sav_q;
  assign eav_pulse = eav_q;
  assign field     = field_q;
  assign vblank    = vblank_q;
  assign hblank    = hblank_q;
  assign line_cnt  = line_q;
  assign code_err  = code_err_q;
  assign len_err   = len_err_q;
  assign sync_lock = lock_q;

endmodule
